// File: rtl/trace_reader.sv
// Streams a captured 256-sample frame as screen-row beats, reporting the frame min/max.
// Latency: 2 cycles from buf_full to first beat; reads run through a 2-entry skid FIFO.
// Backpressure: reads stall once 2 samples are buffered or in flight; payload holds while m_ready is low.
module trace_reader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 12,
    parameter int Y_W    = 9,
    parameter int SHIFT  = 3,
    parameter int Y_MAX  = 479
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_full,
    output logic              buf_release,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_x,
    output logic [Y_W-1:0]    m_y,
    output logic              m_last,
    output logic              busy,
    output logic [DATA_W-1:0] frame_min,
    output logic [DATA_W-1:0] frame_max
);

    typedef enum logic [1:0] {IDLE, STREAM, RELEASE, HOLD} state_t;

    state_t              state;
    logic                rd_done;
    logic                inflight;
    logic [ADDR_W-1:0]   inflight_tag;
    logic [DATA_W-1:0]   fifo_dat [2];
    logic [ADDR_W-1:0]   fifo_tag [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_cnt;
    logic [DATA_W-1:0]   run_min;
    logic [DATA_W-1:0]   run_max;
    logic                pop;
    logic                fifo_push;
    logic                fifo_pop;
    logic [2:0]          pending;
    logic [DATA_W-1:0]   head_dat;
    logic [ADDR_W-1:0]   head_tag;

    function automatic logic [Y_W-1:0] to_row(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] s;
        s = d >> SHIFT;
        if (s >= DATA_W'(Y_MAX))
            return '0;
        return Y_W'(Y_MAX) - Y_W'(s);
    endfunction

    // When the FIFO is empty the returning read is presented directly, so a
    // sample is on the output the cycle its data arrives; if it is not taken
    // it is pushed and re-presented unchanged from the FIFO.
    always_comb begin
        head_dat  = rd_data;
        head_tag  = inflight_tag;
        if (fifo_cnt != 2'd0) begin
            head_dat = fifo_dat[rd_ptr];
            head_tag = fifo_tag[rd_ptr];
        end
        m_valid   = (fifo_cnt != 2'd0) || inflight;
        pop       = m_valid && m_ready;
        fifo_push = inflight && !(pop && fifo_cnt == 2'd0);
        fifo_pop  = pop && (fifo_cnt != 2'd0);
        pending   = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
        rd_en     = (state == STREAM) && !rd_done && (pending < 3'd2);
        m_x       = m_valid ? head_tag : '0;
        m_y       = m_valid ? to_row(head_dat) : '0;
        m_last    = m_valid && (head_tag == ADDR_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            buf_release <= 1'b0;
            busy        <= 1'b0;
            frame_min   <= '0;
            frame_max   <= '0;
        end else begin
            buf_release <= 1'b0;
            case (state)
                IDLE: if (buf_full) begin
                    state <= STREAM;
                    busy  <= 1'b1;
                end
                STREAM: if (pop && m_last) begin
                    state       <= RELEASE;
                    buf_release <= 1'b1;
                end
                RELEASE: begin
                    state     <= HOLD;
                    frame_min <= run_min;
                    frame_max <= run_max;
                end
                HOLD: if (!buf_full) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr      <= '0;
            rd_done      <= 1'b0;
            inflight     <= 1'b0;
            inflight_tag <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_cnt     <= 2'd0;
            run_min      <= '1;
            run_max      <= '0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                inflight_tag <= rd_addr;
                if (rd_addr == ADDR_W'(DEPTH - 1))
                    rd_done <= 1'b1;
                else
                    rd_addr <= rd_addr + 1'b1;
            end
            if (fifo_push)
                wr_ptr <= ~wr_ptr;
            if (fifo_pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
            if (inflight) begin
                if (rd_data < run_min) run_min <= rd_data;
                if (rd_data > run_max) run_max <= rd_data;
            end
            if (state == IDLE && buf_full) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
                run_min <= '1;
                run_max <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_dat[wr_ptr] <= rd_data;
            fifo_tag[wr_ptr] <= inflight_tag;
        end
    end

endmodule

// File: tb/tb_trace_reader.sv
// Scoreboard bench for trace_reader: directed frames with expected beats queued at stimulus time.
module tb_trace_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        buf_full;
    logic        buf_release;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [11:0] rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_x;
    logic [8:0]  m_y;
    logic        m_last;
    logic        busy;
    logic [11:0] frame_min;
    logic [11:0] frame_max;

    trace_reader dut (
        .clk(clk), .rst(rst), .buf_full(buf_full), .buf_release(buf_release),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_last(m_last),
        .busy(busy), .frame_min(frame_min), .frame_max(frame_max)
    );

    always #5 clk = ~clk;

    logic [11:0] mem [256];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    typedef struct packed {
        logic [7:0] x;
        logic [8:0] y;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    int    exp_rd_addr = 0;
    int    outstanding = 0;
    int    rd_count = 0;
    int    rel_count = 0;
    int    beat_count = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int exp_y(input int d);
        int s;
        s = d / 8;
        return (s >= 479) ? 0 : 479 - s;
    endfunction

    // Monitor: pops the scoreboard on each accepted beat, checks stability and read ordering.
    always @(negedge clk) begin
        beat_t cur;
        cur = '{x: m_x, y: m_y, last: m_last};
        if (rst) begin
            prev_stall  = 1'b0;
            exp_rd_addr = 0;
            outstanding = 0;
        end else begin
            if (buf_release) begin
                rel_count++;
                exp_rd_addr = 0;
            end
            if (rd_en) begin
                chk("rd_in_range", 32'(exp_rd_addr < 256), 32'd1);
                chk("rd_addr", 32'(rd_addr), 32'(exp_rd_addr & 255));
                exp_rd_addr++;
                rd_count++;
                outstanding++;
            end
            if (prev_stall) begin
                chk("valid_held", 32'(m_valid), 32'd1);
                chk("payload_held", 32'(cur), 32'(prev_beat));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat_x", 32'(m_x), 32'hFFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat", 32'(cur), 32'(e));
                end
                beat_count++;
                outstanding--;
            end
            if (rd_en)
                chk("outstanding_le2", 32'(outstanding <= 2), 32'd1);
            prev_stall = m_valid && !m_ready;
            prev_beat  = cur;
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_x"}, 32'(m_x), 0);
        chk({tag, "_m_y"}, 32'(m_y), 0);
        chk({tag, "_m_last"}, 32'(m_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_release"}, 32'(buf_release), 0);
        chk({tag, "_fmin"}, 32'(frame_min), 0);
        chk({tag, "_fmax"}, 32'(frame_max), 0);
    endtask

    // mode 0: always ready; mode 1: ready 1-in-3 plus a 20-cycle stall.
    task automatic run_frame(input int mode, input int glitch_at, input bit check_lat,
                             output int rel_cycle);
        rel_cycle = -1;
        @(posedge clk); #1;
        buf_full = 1'b1;
        m_ready  = (mode == 0);
        @(posedge clk);
        for (int n = 1; n < 3000; n++) begin
            #1;
            if (mode == 0) m_ready = 1'b1;
            else           m_ready = (n % 3 == 0) && !(n >= 300 && n < 320);
            if (n == glitch_at) buf_full = 1'b0;
            @(negedge clk);
            if (check_lat && n == 1) begin
                chk("lat_rd_en", 32'(rd_en), 1);
                chk("lat_rd_addr", 32'(rd_addr), 0);
                chk("lat_m_valid_early", 32'(m_valid), 0);
                chk("lat_busy", 32'(busy), 1);
            end
            if (check_lat && n == 2) begin
                chk("lat_m_valid", 32'(m_valid), 1);
                chk("lat_m_x", 32'(m_x), 0);
            end
            if (buf_release) begin
                rel_cycle = n;
                break;
            end
            @(posedge clk);
        end
        chk("release_seen", 32'(rel_cycle >= 0), 1);
        m_ready = 1'b1;
    endtask

    initial begin
        int rel, base_rel, base_rd, base_beats, lo, hi;
        rst = 1'b1; buf_full = 1'b0; m_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Ramp frame, full throughput.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 12'(16 * i);
            exp_q.push_back('{x: 8'(i), y: 9'(479 - ((2 * i < 479) ? 2 * i : 479)), last: (i == 255)});
        end
        base_rel = rel_count;
        run_frame(0, 0, 1'b1, rel);
        chk("ramp_release_cycle", 32'(rel), 258);
        repeat (3) @(negedge clk);
        chk("ramp_queue_empty", 32'(exp_q.size()), 0);
        chk("ramp_release_once", 32'(rel_count - base_rel), 1);
        chk("ramp_min", 32'(frame_min), 0);
        chk("ramp_max", 32'(frame_max), 4080);

        // Handoff: buf_full still high, no re-read.
        base_rd = rd_count;
        repeat (10) @(negedge clk);
        chk("hold_busy", 32'(busy), 1);
        chk("hold_no_read", 32'(rd_count - base_rd), 0);
        chk("hold_no_release", 32'(rel_count - base_rel), 1);
        #1 buf_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_drop", 32'(busy), 0);

        // Clamp/invert samples at the front, backpressure throughout.
        mem[0] = 12'd0; mem[1] = 12'd3832; mem[2] = 12'd3839; mem[3] = 12'd4095;
        exp_q.push_back('{x: 8'd0, y: 9'd479, last: 1'b0});
        exp_q.push_back('{x: 8'd1, y: 9'd0,   last: 1'b0});
        exp_q.push_back('{x: 8'd2, y: 9'd0,   last: 1'b0});
        exp_q.push_back('{x: 8'd3, y: 9'd0,   last: 1'b0});
        for (int i = 4; i < 256; i++) begin
            mem[i] = 12'((i * 16 + 5) % 4096);
            exp_q.push_back('{x: 8'(i), y: 9'(exp_y((i * 16 + 5) % 4096)), last: (i == 255)});
        end
        base_beats = beat_count;
        run_frame(1, 0, 1'b0, rel);
        repeat (3) @(negedge clk);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);
        chk("bp_beats", 32'(beat_count - base_beats), 256);
        chk("bp_min", 32'(frame_min), 0);
        chk("bp_max", 32'(frame_max), 4095);
        #1 buf_full = 1'b0;
        repeat (2) @(negedge clk);

        // Reset after beat 100.
        for (int i = 0; i < 256; i++) begin
            mem[i] = 12'((i * 37) % 4096);
            exp_q.push_back('{x: 8'(i), y: 9'(exp_y((i * 37) % 4096)), last: (i == 255)});
        end
        base_beats = beat_count;
        base_rel   = rel_count;
        @(posedge clk); #1 buf_full = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 1000 && beat_count < base_beats + 101; k++) @(negedge clk);
        chk("mid_beats_reached", 32'(beat_count - base_beats), 101);
        @(posedge clk); #1 rst = 1'b1; buf_full = 1'b0;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        repeat (5) @(negedge clk);
        chk("midrst_no_release", 32'(rel_count - base_rel), 0);

        // Restart from m_x=0, with buf_full dropping mid-stream.
        lo = 4095; hi = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 12'((i * 53 + 100) % 4096);
            if (int'(mem[i]) < lo) lo = int'(mem[i]);
            if (int'(mem[i]) > hi) hi = int'(mem[i]);
            exp_q.push_back('{x: 8'(i), y: 9'(exp_y((i * 53 + 100) % 4096)), last: (i == 255)});
        end
        base_rel = rel_count;
        run_frame(0, 50, 1'b1, rel);
        chk("glitch_release_cycle", 32'(rel), 258);
        repeat (3) @(negedge clk);
        chk("glitch_queue_empty", 32'(exp_q.size()), 0);
        chk("glitch_release_once", 32'(rel_count - base_rel), 1);
        chk("glitch_min", 32'(frame_min), 32'(lo));
        chk("glitch_max", 32'(frame_max), 32'(hi));
        chk("glitch_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
